// File: rtl/ad_spi_rd.sv
// rtl/ad_spi_rd.sv - SPI mode-0 read master shifting one DATA_W-bit ADC sample per frame.
// Define AD_SPI_CONT_EN for free-running acquisition (start_i ignored).
module ad_spi_rd #(
  parameter int CLK_DIV  = 4,
  parameter int DATA_W   = 16,
  parameter int CONV_GAP = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              sdo_i,
  output logic              sclk_o,
  output logic              cs_o,
  output logic [DATA_W-1:0] adc_data_o,
  output logic              adc_data_valid_o,
  output logic              busy_o
);

  localparam int CMAX = (CLK_DIV > CONV_GAP) ? CLK_DIV : CONV_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CONV_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              sclk_d, cs_d, valid_d, busy_d;
  logic [DATA_W-1:0] data_d;
  logic              go;

`ifdef AD_SPI_CONT_EN
  assign go = 1'b1;
`else
  assign go = start_i;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      bit_q            <= '0;
      shift_q          <= '0;
      sclk_o           <= 1'b0;
      cs_o             <= 1'b1;
      adc_data_o       <= '0;
      adc_data_valid_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bit_q            <= bit_d;
      shift_q          <= shift_d;
      sclk_o           <= sclk_d;
      cs_o             <= cs_d;
      adc_data_o       <= data_d;
      adc_data_valid_o <= valid_d;
      busy_o           <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_o;
    cs_d    = cs_o;
    data_d  = adc_data_o;
    valid_d = 1'b0;
    busy_d  = busy_o;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = CS_SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          shift_d = '0;
        end
      end

      CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Sample sdo_i on the same edge that raises sclk_o; the ADC moves it on the fall.
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_o) begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[DATA_W-2:0], sdo_i};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = CS_HOLD;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CS_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          cs_d    = 1'b1;
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
`ifdef AD_SPI_CONT_EN
          state_d = CS_SETUP;
          cs_d    = 1'b0;
          shift_d = '0;
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ad_spi_rd.sv
// tb/tb_ad_spi_rd.sv - scoreboard bench for ad_spi_rd with a mode-0 ADC model.
module tb_ad_spi_rd;

  localparam int CLK_DIV  = 4;
  localparam int DATA_W   = 16;
  localparam int CONV_GAP = 8;
  localparam int LOW_LEN  = 2 * CLK_DIV * (DATA_W + 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              sdo = 1'b0;
  logic              sclk, cs, valid, busy;
  logic [DATA_W-1:0] data;

  always #5 clk = ~clk;

  ad_spi_rd #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .CONV_GAP(CONV_GAP)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .start_i          (start),
    .sdo_i            (sdo),
    .sclk_o           (sclk),
    .cs_o             (cs),
    .adc_data_o       (data),
    .adc_data_valid_o (valid),
    .busy_o           (busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ADC: MSB valid from cs fall, next bit after each sclk fall
  logic [DATA_W-1:0] adc_word = '0;
  int bit_idx = 0;
  always @(negedge cs) begin
    bit_idx = DATA_W - 1;
    sdo = adc_word[DATA_W-1];
  end
  always @(negedge sclk) begin
    if (!cs && bit_idx > 0) begin
      bit_idx--;
      sdo = adc_word[bit_idx];
    end
  end

  logic [DATA_W-1:0] sb[$];

  logic              prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0;
  logic              stable_ok = 1'b1;
  logic [DATA_W-1:0] held = '0;
  int                fall_cyc = 0, rise_cyc = 0, rises = 0;
  bit                held_mode = 1'b0, rise_in_held = 1'b0;
  int                exp_gap = 0, exp_period = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_cs      = 1'b1;
      prev_sclk    = 1'b0;
      prev_valid   = 1'b0;
      held         = '0;
      stable_ok    = 1'b1;
      rise_in_held = 1'b0;
    end else begin
      if (sclk && !prev_sclk) begin
        check("sclk_rise_cs_low", cs, 1'b0);
        rises++;
      end
      if (!cs && prev_cs) begin
        if (held_mode && rise_in_held) begin
          check("cs_high_gap", cyc - rise_cyc, exp_gap);
          check("frame_period", cyc - fall_cyc, exp_period);
        end
        fall_cyc = cyc;
        rises = 0;
      end
      if (cs && !prev_cs) begin
        rise_cyc = cyc;
        rise_in_held = held_mode;
        check("cs_low_len", cyc - fall_cyc, LOW_LEN);
        check("sclk_rises", rises, DATA_W);
      end
      if (valid) begin
        check("valid_one_cycle", prev_valid, 1'b0);
        check("hold_between", stable_ok, 1'b1);
        check("latency", cyc - fall_cyc, LOW_LEN);
        check("sb_pending", sb.size() > 0, 1'b1);
        if (sb.size() > 0) check("adc_data", data, sb.pop_front());
        stable_ok = 1'b1;
        held = data;
      end else if (data !== held) begin
        stable_ok = 1'b0;
      end
      prev_cs = cs;
      prev_sclk = sclk;
      prev_valid = valid;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, busy, 1'b0);
    check({name, "_busy_fall"}, cyc - rise_cyc, CONV_GAP);
  endtask

  task automatic wait_sb(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb.size(), 0);
  endtask

  task automatic run_frame(input string name, input logic [DATA_W-1:0] w);
    adc_word = w;
    sb.push_back(w);
    pulse_start();
    wait_idle(name);
  endtask

  initial begin
    adc_word = 16'h856B;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_data", data, 0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);

`ifdef AD_SPI_CONT_EN
    exp_gap = CONV_GAP;
    exp_period = LOW_LEN + CONV_GAP;
    held_mode = 1'b1;
    repeat (3) sb.push_back(16'h856B);
    @(negedge clk) reset_n = 1'b1;
    wait_sb(3 * (LOW_LEN + CONV_GAP) + 50);
    held_mode = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
`else
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("f856b", 16'h856B);
    run_frame("fffff", 16'hFFFF);
    run_frame("f0000", 16'h0000);
    run_frame("fa5a5", 16'hA5A5);

    adc_word = 16'h3C96;
    sb.push_back(16'h3C96);
    pulse_start();
    repeat (49) @(negedge clk);
    pulse_start();
    wait_idle("midstart");
    repeat (20) @(negedge clk);
    check("no_queued_start", busy, 1'b0);
    check("one_valid_only", sb.size(), 0);

    adc_word = 16'h5A5A;
    pulse_start();
    repeat (69) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_cs", cs, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_data", data, 0);
    check("abort_valid", valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_frame("after_rst", 16'h856B);

    exp_gap = CONV_GAP + 1;
    exp_period = LOW_LEN + CONV_GAP + 1;
    adc_word = 16'h1E2D;
    repeat (3) sb.push_back(16'h1E2D);
    held_mode = 1'b1;
    @(negedge clk) start = 1'b1;
    wait_sb(3 * (LOW_LEN + CONV_GAP + 1) + 50);
    start = 1'b0;
    held_mode = 1'b0;
    wait_idle("held");
`endif

    check("sb_empty_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
